// File: rtl/approx_mac_pkg.sv
// Purpose : shared types/constants for the approximate-MAC accumulator slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_t (IDLE/ACC/DONE) and PROD_W, the multiplier product width.
package approx_mac_pkg;

    // Product width of the 8x8 approximate multiplier; the wrapper uses it too.
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/acc_add_sat.sv
// Purpose : combinational ACC_W-bit add of a zero-extended product, with carry out.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller qualifies the result with its own accept.
// Ports   : acc_in (running sum), prod_in (product), sum (next sum), carry (carry out of ACC_W).
// Config  : APPROX_MAC_SAT_EN clamps sum to all-ones on carry; otherwise sum wraps.
module acc_add_sat #(
    parameter int PROD_W = approx_mac_pkg::PROD_W,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod_in,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] full_sum;

    // One extra bit captures the carry; the product is zero-extended.
    assign full_sum = {1'b0, acc_in} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
    assign carry    = full_sum[ACC_W];

`ifdef APPROX_MAC_SAT_EN
    // A saturated accumulator plus any nonzero product carries again, so it
    // stays pinned at max until the caller restarts from zero.
    assign sum = carry ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/approx_mac_acc.sv
// Purpose : accumulates LEN products (or fewer, up to in_last) into an ACC_W-bit sum.
// Latency : out_valid rises the cycle after the terminal beat is accepted.
// Backpr. : in_ready drops only while a result waits with out_ready low.
// Ports   : clk/rst (async active-high); in_valid/in_ready/in_prod/in_last beat input;
//           out_valid/out_ready result handshake with acc_out, beat_cnt, sticky ovf.
// Config  : APPROX_MAC_SAT_EN (in acc_add_sat) saturates instead of wrapping.
// Note    : ACC_W must be >= PROD_W+1 and LEN >= 1.
module approx_mac_acc #(
    parameter int  PROD_W = approx_mac_pkg::PROD_W,
    parameter int  ACC_W  = 24,
    parameter int  LEN    = 16,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              ovf
);

    import approx_mac_pkg::*;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               in_acc;
    logic               accept;
    logic               terminal;
    logic [ACC_W-1:0]   add_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   cnt_inc;

    // Ready while no result is pending, or when the pending result is being
    // taken this very cycle, so back-to-back accumulations lose no cycle.
    assign in_ready = (state_q != DONE) || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_acc   = (state_q == ACC);

    // Outside ACC every accepted beat starts a fresh sum: adding to zero
    // makes the same adder serve both the first beat and later ones.
    assign add_base = in_acc ? acc_q : '0;
    assign cnt_inc  = (in_acc ? cnt_q : '0) + CNT_W'(1);
    // in_last and reaching LEN on the same beat collapse into one termination.
    assign terminal = in_last || (cnt_inc == CNT_W'(LEN));

    acc_add_sat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in  (add_base),
        .prod_in (in_prod),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = (in_acc && ovf_q) || add_carry;
        end

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    state_d = terminal ? DONE : ACC;
                end
            end
            DONE: begin
                // accept in DONE implies out_ready: result handed off and a
                // new accumulation begins in the same cycle.
                if (accept) begin
                    state_d = terminal ? DONE : ACC;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign beat_cnt  = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/approx_mac_acc.md
Name: approx_mac_acc

Overview:
- Downstream consumer of the 8x8 approximate multiplier's 16-bit product (prod8).
- Accumulates a stream of products into a wide accumulator, forming approximate dot products for application-level error evaluation.
- Sits between the combinational multiplier and the result sink. Uses valid/ready handshakes on both sides.

Parameters:
- PROD_W, 16, input product width; must match the multiplier output.
- ACC_W, 24, accumulator width; must be >= PROD_W+1.
- LEN, 16, products per accumulation; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_prod  input  PROD_W  product from the multiplier.
- in_last  input  1  marks the final beat of an accumulation (early terminate).
- out_valid  output  1  accumulated result valid.
- out_ready  input  1  sink accepts the result.
- acc_out  output  ACC_W  accumulated sum.
- beat_cnt  output  $clog2(LEN+1)  beats summed into acc_out.
- ovf  output  1  sticky: overflow occurred in this accumulation.

Behaviour:
- Reset values (async): state=IDLE, acc_out=0, beat_cnt=0, out_valid=0, ovf=0.
- A beat is accepted on a cycle with in_valid && in_ready.
- Products are zero-extended to ACC_W.
- States: IDLE, ACC, DONE.
- in_ready:
  - 1 in IDLE and ACC.
  - Equals out_ready in DONE, so a new accumulation can start in the result-handshake cycle.
- out_valid = (state==DONE). It is registered and depends only on state.
- Terminal beat: the accepted beat where beat_cnt+1==LEN or in_last=1.
- IDLE:
  - On accept: acc_out<=prod, beat_cnt<=1, ovf<=0.
  - Go to DONE if it is the terminal beat, else ACC.
- ACC:
  - On accept: acc_out<=acc_out+prod, beat_cnt++, ovf|=carry-out.
  - Go to DONE on the terminal beat.
  - No accept: hold all state.
- DONE:
  - acc_out, beat_cnt and ovf are held stable while out_ready=0.
  - On out_ready with no accepted beat: go to IDLE and hold acc_out.
  - On out_ready with an accepted beat: restart as in IDLE (acc_out<=prod, beat_cnt<=1, ovf<=0). Next state is ACC, or DONE if that beat is terminal.
- Latency: out_valid rises the cycle after the terminal beat is accepted.
- Peak throughput: one beat per cycle. One dead cycle per accumulation only if out_ready is low in the DONE cycle.
- Arithmetic: without the optional feature, the sum wraps modulo 2^ACC_W.
- in_valid gaps: beat_cnt and acc_out do not change.
- in_last with LEN reached on the same beat: single termination, no double count.
- Reset mid-accumulation: partial sum discarded, all outputs return to reset values immediately.

Optional Feature:
- Macro: APPROX_MAC_SAT_EN.
- When defined: the accumulator saturates at 2^ACC_W-1 instead of wrapping. Once saturated it stays at max until a new accumulation starts. ovf is set identically in both builds.
- When undefined: modular wrap. The saturation logic is absent.

Decomposition:
- Package approx_mac_pkg:
  - State enum type (IDLE, ACC, DONE).
  - Localparam PROD_W=16, shared with the multiplier wrapper.
- One sub-module: acc_add_sat.
  - Combinational ACC_W-bit add of zero-extended prod.
  - Outputs sum and carry.
  - Contains the APPROX_MAC_SAT_EN clamp.
- The FSM and registers stay in approx_mac_acc.

Test Plan:
- LEN=4, out_ready=1, prods 100,200,300,400 back-to-back -> out_valid one cycle after the 4th accept; acc_out=1000, beat_cnt=4, ovf=0, pulse lasts 1 cycle.
- LEN=16, prods 65535 then 1 with in_last on the 2nd -> acc_out=65536, beat_cnt=2; next beat starts a fresh sum.
- Backpressure: result pending, out_ready=0 for 5 cycles -> in_ready=0 and acc_out stable. Then out_ready=1 with in_valid, prod=7 in the same cycle -> acc_out=7, beat_cnt=1, state ACC.
- Overflow with ACC_W=17, LEN=4, four beats of 65535:
  - Wrap build: acc_out=131068, ovf=1.
  - APPROX_MAC_SAT_EN build: acc_out=131071, ovf=1.
- Bubbles: LEN=3, prods 5,_,_,6,_,9 with in_valid low on the gaps -> acc_out=20, beat_cnt=3; out_valid only after the 9.
- Assert rst after 2 beats of a LEN=4 run -> all outputs 0 asynchronously. After release, prods 1,2,3,4 -> acc_out=10.
